// File: rtl/aux_run_controller_pkg.sv
// Shared run-state and halt-cause encodings for the run-control sequencer.
// Also holds the debounce counter width helper.
package aux_run_controller_pkg;

  typedef enum logic [1:0] {
    RUN_ST_RUN  = 2'd0,
    RUN_ST_HALT = 2'd1,
    RUN_ST_STEP = 2'd2
  } run_state_e;

  typedef enum logic [1:0] {
    HALT_CAUSE_NONE    = 2'd0,
    HALT_CAUSE_SYSCALL = 2'd1,
    HALT_CAUSE_STEP    = 2'd2,
    HALT_CAUSE_BREAK   = 2'd3
  } halt_cause_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aux_run_controller_btn.sv
// Button conditioner: 2-flop synchroniser, stability down-counter, and a
// one-cycle pulse on each 0->1 change of the accepted level.
module aux_btn_debounce
  import aux_run_controller_pkg::*;
#(
  parameter int DebounceCnt = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CntW = cnt_width(DebounceCnt);
  localparam logic [CntW-1:0] CntLoad = CntW'(DebounceCnt - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_pulse;
  logic [CntW-1:0] r_cnt;
  logic            w_differs;
  logic            w_accept;

  // The counter only runs while the synchronised sample disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  assign w_differs = (r_sync2 != r_level);
  assign w_accept  = w_differs && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= CntLoad;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_pulse <= w_accept & r_sync2;
      if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= CntLoad;
      end else if (w_differs) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= CntLoad;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/aux_run_controller.sv
// RUN/HALT/STEP run-control sequencer driving the core enable.
// Optional PC breakpoint enabled by defining AUX_RUN_BRK_EN.
module aux_run_controller
  import aux_run_controller_pkg::*;
#(
  parameter int DebounceCnt = 4,
  parameter int PcBits      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_resume_btn,
  input  logic              i_step_btn,
  input  logic              i_core_halt,
  input  logic [PcBits-1:0] i_core_pc,
  input  logic              i_brk_valid,
  input  logic [PcBits-1:0] i_brk_addr,
  output logic              o_core_en,
  output logic [1:0]        o_run_state,
  output logic [1:0]        o_halt_cause
);

  run_state_e  r_state;
  run_state_e  w_state_nxt;
  halt_cause_e r_cause;
  halt_cause_e w_cause_nxt;
  logic        w_res_p;
  logic        w_step_p;
  logic        w_brk_hit;

  aux_btn_debounce #(.DebounceCnt(DebounceCnt)) u_res_db (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_resume_btn),
    .o_pulse(w_res_p)
  );

  aux_btn_debounce #(.DebounceCnt(DebounceCnt)) u_step_db (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_step_btn),
    .o_pulse(w_step_p)
  );

`ifdef AUX_RUN_BRK_EN
  logic r_brk_skip;
  logic w_leave_brk;

  // The skip flag lets the breakpointed instruction execute once after a resume.
  assign w_brk_hit   = i_brk_valid & (i_core_pc == i_brk_addr) & ~r_brk_skip;
  assign w_leave_brk = (r_state == RUN_ST_HALT) && (w_state_nxt != RUN_ST_HALT) &&
                       (r_cause == HALT_CAUSE_BREAK);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_brk_skip <= 1'b0;
    end else if (o_core_en) begin
      r_brk_skip <= 1'b0;
    end else if (w_leave_brk) begin
      r_brk_skip <= 1'b1;
    end
  end
`else
  logic w_unused_brk;
  assign w_unused_brk = ^{i_brk_valid, i_brk_addr};
  assign w_brk_hit    = 1'b0;
`endif

  assign o_core_en = ((r_state == RUN_ST_RUN) & ~w_brk_hit) | (r_state == RUN_ST_STEP);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RUN_ST_RUN;
      r_cause <= HALT_CAUSE_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    case (r_state)
      RUN_ST_RUN: begin
        // A hit gates core_en low, so core_halt cannot count in the same cycle.
        if (w_brk_hit) begin
          w_state_nxt = RUN_ST_HALT;
          w_cause_nxt = HALT_CAUSE_BREAK;
        end else if (i_core_halt) begin
          w_state_nxt = RUN_ST_HALT;
          w_cause_nxt = HALT_CAUSE_SYSCALL;
        end
      end
      RUN_ST_HALT: begin
        if (w_step_p) begin
          w_state_nxt = RUN_ST_STEP;
        end else if (w_res_p) begin
          w_state_nxt = RUN_ST_RUN;
        end
      end
      RUN_ST_STEP: begin
        w_state_nxt = RUN_ST_HALT;
        w_cause_nxt = i_core_halt ? HALT_CAUSE_SYSCALL : HALT_CAUSE_STEP;
      end
      default: begin
        w_state_nxt = RUN_ST_RUN;
      end
    endcase
  end

  assign o_run_state  = r_state;
  assign o_halt_cause = r_cause;

endmodule

// File: tb/tb_aux_run_controller.sv
// Self-checking bench for aux_run_controller: directed vector table plus
// randomized stimulus against a cycle-level behavioural model.
module tb_aux_run_controller;

  localparam int N = 2;
`ifdef AUX_RUN_BRK_EN
  localparam bit BrkEn = 1'b1;
`else
  localparam bit BrkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, res_btn, step_btn, core_halt, brk_valid;
  logic [31:0] core_pc, brk_addr;
  logic        core_en;
  logic [1:0]  run_state, halt_cause;

  always #5 clk = ~clk;

  aux_run_controller #(.DebounceCnt(N), .PcBits(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_resume_btn(res_btn),
    .i_step_btn  (step_btn),
    .i_core_halt (core_halt),
    .i_core_pc   (core_pc),
    .i_brk_valid (brk_valid),
    .i_brk_addr  (brk_addr),
    .o_core_en   (core_en),
    .o_run_state (run_state),
    .o_halt_cause(halt_cause)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checks_on = 1'b0;

  // Behavioural model: state 0=RUN 1=HALT 2=STEP, cause 0..3.
  int           m_state = 0;
  int           m_cause = 0;
  bit           m_skip = 1'b0;
  logic [N+1:0] res_hist = '0;
  logic [N+1:0] step_hist = '0;
  bit           res_lvl = 1'b0, step_lvl = 1'b0, res_pul = 1'b0, step_pul = 1'b0;

  function automatic bit m_hit();
    return BrkEn && brk_valid && (core_pc == brk_addr) && !m_skip;
  endfunction

  function automatic bit m_en();
    return ((m_state == 0) && !m_hit()) || (m_state == 2);
  endfunction

  // Raw sample taken at edge e reaches the stability window two edges later;
  // the level flips once N consecutive windowed samples agree on the new value.
  function automatic void deb_step(input bit raw, inout logic [N+1:0] hist,
                                   inout bit lvl, output bit pul);
    logic [N-1:0] win;
    hist = {hist[N:0], raw};
    win  = hist[N+1:2];
    pul  = 1'b0;
    if (!lvl && (&win)) begin
      lvl = 1'b1;
      pul = 1'b1;
    end else if (lvl && !(|win)) begin
      lvl = 1'b0;
    end
  endfunction

  function automatic void model_update();
    bit en, hit, rp, sp;
    if (rst) begin
      m_state = 0; m_cause = 0; m_skip = 1'b0;
      res_hist = '0; step_hist = '0;
      res_lvl = 1'b0; step_lvl = 1'b0; res_pul = 1'b0; step_pul = 1'b0;
      return;
    end
    hit = m_hit();
    en  = m_en();
    case (m_state)
      0: begin
        if (hit) begin m_state = 1; m_cause = 3; end
        else if (core_halt) begin m_state = 1; m_cause = 1; end
      end
      1: begin
        if ((m_cause == 3) && (step_pul || res_pul)) m_skip = 1'b1;
        if (step_pul) m_state = 2;
        else if (res_pul) m_state = 0;
      end
      default: begin
        m_state = 1;
        m_cause = core_halt ? 1 : 2;
      end
    endcase
    if (en) m_skip = 1'b0;
    deb_step(res_btn, res_hist, res_lvl, rp);
    deb_step(step_btn, step_hist, step_lvl, sp);
    res_pul  = rp;
    step_pul = sp;
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got en=%0b st=%0d cause=%0d, expected en=%0b st=%0d cause=%0d",
               name, got[4], got[3:2], got[1:0], exp[4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic drive(input bit r, input bit rb, input bit sb, input bit h,
                       input logic [31:0] pc, input bit v, input logic [31:0] a);
    @(negedge clk);
    rst = r; res_btn = rb; step_btn = sb; core_halt = h;
    core_pc = pc; brk_valid = v; brk_addr = a;
    #1;
    if (checks_on)
      check("model", {core_en, run_state, halt_cause}, {m_en(), 2'(m_state), 2'(m_cause)});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    if (rst) checks_on = 1'b1;
  endtask

  typedef struct {
    bit          rst, res, step, halt, valid, chk;
    logic [31:0] pc, addr;
    logic [4:0]  exp;
    int          reps;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input bit rb, input bit sb, input bit h,
                              input logic [31:0] pc, input bit v, input logic [31:0] a,
                              input bit chk, input bit en, input int st, input int cs,
                              input int reps);
    vec_t x;
    x.rst = r; x.res = rb; x.step = sb; x.halt = h; x.pc = pc; x.valid = v; x.addr = a;
    x.chk = chk; x.exp = {en, 2'(st), 2'(cs)}; x.reps = reps;
    tbl.push_back(x);
  endfunction

  initial begin
    bit rb = 1'b0, sb = 1'b0;
    logic [31:0] pc;
    rst = 1'b1; res_btn = 1'b0; step_btn = 1'b0; core_halt = 1'b0;
    core_pc = '0; brk_valid = 1'b0; brk_addr = '0;

    //   rst res stp hlt pc     v  addr   chk en st cs reps
    add(1, 0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 0, 0, 2);
    add(0, 0, 0, 1, 32'h0,  0, 32'h0,  1, 1, 0, 0, 1);   // syscall executes
    add(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 1, 1, 2);
    add(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 1, 1, 5);   // step held 20 cycles
    add(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 1, 2, 1, 1);
    add(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 1, 2, 14);
    add(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 1, 2, 6);
    add(0, 1, 0, 0, 32'h0,  0, 32'h0,  1, 0, 1, 2, 1);   // resume glitch
    add(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 1, 2, 6);
    add(0, 1, 1, 0, 32'h0,  0, 32'h0,  1, 0, 1, 2, 4);   // both buttons together
    add(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 1, 2, 1);
    add(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 2, 2, 1);
    add(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 1, 2, 4);
    add(0, 1, 0, 0, 32'h0,  0, 32'h0,  1, 0, 1, 2, 5);   // resume
    add(0, 1, 0, 0, 32'h0,  0, 32'h0,  1, 1, 0, 2, 3);
    add(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 0, 2, 4);
    add(0, 0, 0, 1, 32'h0,  0, 32'h0,  1, 1, 0, 2, 1);
    add(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 1, 1, 3);
    add(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 1, 1, 5);
    add(1, 0, 1, 0, 32'h0,  0, 32'h0,  1, 1, 2, 1, 1);   // reset mid-STEP
    add(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 0, 0, 4);
    if (BrkEn) begin
      add(1, 0, 0, 0, 32'h38, 0, 32'h40, 0, 0, 0, 0, 3);
      add(0, 0, 0, 0, 32'h38, 1, 32'h40, 1, 1, 0, 0, 1);
      add(0, 0, 0, 0, 32'h3C, 1, 32'h40, 1, 1, 0, 0, 1);
      add(0, 0, 0, 0, 32'h40, 1, 32'h40, 1, 0, 0, 0, 1); // breakpoint hit
      add(0, 0, 0, 0, 32'h40, 1, 32'h40, 1, 0, 1, 3, 2);
      add(0, 1, 0, 0, 32'h40, 1, 32'h40, 1, 0, 1, 3, 5);
      add(0, 1, 0, 0, 32'h40, 1, 32'h40, 1, 1, 0, 3, 1); // skipped once
      add(0, 1, 0, 0, 32'h44, 1, 32'h40, 1, 1, 0, 3, 1);
      add(0, 0, 0, 0, 32'h48, 1, 32'h40, 1, 1, 0, 3, 3);
      add(0, 0, 0, 0, 32'h40, 1, 32'h40, 1, 0, 0, 3, 1); // loop back
      add(0, 0, 0, 0, 32'h40, 1, 32'h40, 1, 0, 1, 3, 1);
    end

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        drive(tbl[i].rst, tbl[i].res, tbl[i].step, tbl[i].halt,
              tbl[i].pc, tbl[i].valid, tbl[i].addr);
        if (tbl[i].chk)
          check($sformatf("vec%0d.%0d", i, r), {core_en, run_state, halt_cause}, tbl[i].exp);
        tick();
      end
    end

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) rb = ~rb;
      if ($urandom_range(0, 7) == 0) sb = ~sb;
      case ($urandom_range(0, 3))
        0: pc = 32'h40;
        1: pc = 32'h44;
        2: pc = 32'h48;
        default: pc = $urandom;
      endcase
      drive($urandom_range(0, 299) == 0, rb, sb, $urandom_range(0, 5) == 0, pc,
            1'($urandom_range(0, 1)), $urandom_range(0, 1) ? 32'h40 : 32'h44);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
